pipe_hazard_controller: RTL and testbench
=========================================

Name: pipe_hazard_controller

Overview:
- Next-generation main controller for the 5-stage MIPS pipeline.
- Decodes the ID-stage opcode and registers the control bundle through internal ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use and branch-operand hazards and inserts stalls/bubbles; resolves beq/bne/j in ID with IF/ID flush.
- Parametrised in register-address width and in the width of the optional statistics counters.

Parameters:
REG_AW, 5, register-file address width (rs/rt/rd fields)
CNT_W, 16, width of the stall/flush statistics counters (optional feature)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low
opCode  input  6  opcode of the instruction in ID
equal  input  1  ID-stage register comparator result (rs == rt)
id_rs  input  REG_AW  rs field in ID
id_rt  input  REG_AW  rt field in ID
id_rd  input  REG_AW  rd field in ID
pcSrc  output  2  00 = PC+4, 01 = branch target, 10 = jump target
pc_write  output  1  PC load enable (0 = hold)
ifid_write  output  1  IF/ID load enable (0 = hold)
clear_IFID  output  1  IF/ID flush
ex_ALUSrc  output  1  EX: immediate operand select
ex_ALUOperation  output  2  EX: 00 add, 01 sub, 10 funct-decoded, 11 and
ex_regDst  output  1  EX: 1 = rd, 0 = rt destination
mem_memRead  output  1  MEM read enable
mem_memWrite  output  1  MEM write enable
wb_regWrite  output  1  WB register write enable
wb_memtoReg  output  1  WB: 1 = memory data, 0 = ALU result
stall_count  output  CNT_W  stall cycles counted (optional feature)
flush_count  output  CNT_W  IF/ID flushes counted (optional feature)

Behaviour:
- Decode (combinational, ID):
  - R-type 000000: regWrite, regDst, ALUOp 10.
  - addi 001000: regWrite, ALUSrc, ALUOp 00.
  - andi 001100: regWrite, ALUSrc, ALUOp 11.
  - lw 100011: regWrite, ALUSrc, memRead, memtoReg, ALUOp 00.
  - sw 101011: memWrite, ALUSrc, ALUOp 00.
  - beq 000100, bne 000101: ALUOp 01, no writes.
  - j 000010: no writes.
  - Any other opcode: all-zero bundle (NOP).
- Source use:
  - Reads rs: R-type, addi, andi, lw, sw, beq, bne.
  - Reads rt: R-type, sw, beq, bne.
  - j reads nothing.
- Destination: id_rd if regDst, else id_rt. It is captured into ID/EX with the bundle and forwarded to EX/MEM.
- Pipeline latency: decoded bundle appears on ex_* 1 cycle after ID, mem_* 2 cycles after, wb_* 3 cycles after. Each stage register shifts every cycle.
- Load-use stall, 1 cycle: EX holds lw, its dest is nonzero, and the dest equals a used source of ID.
- Branch-operand stall, ID holds beq/bne and either:
  - EX has regWrite with nonzero dest equal to id_rs or id_rt, or
  - MEM has memRead with nonzero dest equal to id_rs or id_rt.
  - A branch behind lw therefore stalls 2 cycles.
- Register 0 never causes a hazard.
- During any stall:
  - pc_write = 0, ifid_write = 0.
  - ID/EX loads an all-zero bundle and dest 0 (bubble).
  - pcSrc = 00, clear_IFID = 0; the stall has priority over branch resolution.
- No stall:
  - pc_write = 1, ifid_write = 1.
  - j: pcSrc = 10, clear_IFID = 1.
  - beq with equal=1 or bne with equal=0: pcSrc = 01, clear_IFID = 1.
  - Otherwise pcSrc = 00, clear_IFID = 0.
- Reset (rst low at clk edge):
  - All stage registers, dests and counters cleared, so all ex_/mem_/wb_ outputs read 0 the cycle after.
  - While rst is low, the combinational outputs are forced to pc_write = 0, ifid_write = 0, pcSrc = 00, clear_IFID = 0.
  - Reset mid-stall or mid-flush discards the pending instruction; no partial bundle survives.

Optional Feature:
- Macro PIPE_CTRL_STATS_EN.
- Defined:
  - stall_count increments once per stalled cycle.
  - flush_count increments once per cycle with clear_IFID = 1.
  - Both saturate at all-ones and clear on reset.
- Undefined: no counter logic; both ports tied to 0.

Test Plan:
- Reset, then addi (001000) in ID for 1 cycle -> next cycle ex_ALUSrc=1, ex_ALUOperation=00; 2 cycles later mem_* = 0; 3 cycles later wb_regWrite=1, wb_memtoReg=0.
- lw with rt=5, followed by R-type with rs=5 -> exactly one cycle of pc_write=0, ifid_write=0, and ex_* all 0 the cycle after; no stall if rs=0.
- lw with rt=7, followed by beq with rt=7 -> 2 stall cycles; then equal=1 gives pcSrc=01, clear_IFID=1 in the third cycle.
- bne with equal=1 -> pcSrc=00, clear_IFID=0; with equal=0 -> pcSrc=01, clear_IFID=1.
- j -> pcSrc=10, clear_IFID=1, no stall.
- Opcode 111111 -> full NOP down the pipe.
- rst low during a load-use stall -> next cycle all outputs 0 and counters 0.
- With PIPE_CTRL_STATS_EN and CNT_W=2: 5 stall cycles -> stall_count=3 (saturated).

Source files
------------

// File: rtl/pipe_hazard_controller_if.sv
// ID-stage instruction fields in, pipeline control bundle and hazard controls out.
// The slave modport is the controller; the master modport is the pipeline side.
interface pipe_hazard_controller_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic [5:0]        opCode;
    logic              equal;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [1:0]        pcSrc;
    logic              pc_write;
    logic              ifid_write;
    logic              clear_IFID;
    logic              ex_ALUSrc;
    logic [1:0]        ex_ALUOperation;
    logic              ex_regDst;
    logic              mem_memRead;
    logic              mem_memWrite;
    logic              wb_regWrite;
    logic              wb_memtoReg;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output opCode, equal, id_rs, id_rt, id_rd,
        input  pcSrc, pc_write, ifid_write, clear_IFID, ex_ALUSrc, ex_ALUOperation, ex_regDst,
        input  mem_memRead, mem_memWrite, wb_regWrite, wb_memtoReg, stall_count, flush_count
    );

    modport slave (
        input  opCode, equal, id_rs, id_rt, id_rd,
        output pcSrc, pc_write, ifid_write, clear_IFID, ex_ALUSrc, ex_ALUOperation, ex_regDst,
        output mem_memRead, mem_memWrite, wb_regWrite, wb_memtoReg, stall_count, flush_count
    );
endinterface

// File: rtl/pipe_hazard_controller.sv
// 5-stage MIPS main controller: ID decode, ID/EX..MEM/WB control registers, hazard stalls and
// ID branch resolution. Define PIPE_CTRL_STATS_EN to enable the saturating stall/flush counters.
module pipe_hazard_controller #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input logic                    clk,
    input logic                    rst,
    pipe_hazard_controller_if.slave bus
);
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;

    logic              id_reg_write, id_reg_dst, id_alu_src, id_mem_read, id_mem_write;
    logic              id_mem_to_reg, uses_rs, uses_rt, is_branch, is_jump;
    logic [1:0]        id_alu_op;
    logic [REG_AW-1:0] id_dest;

    // ID/EX
    logic              ex_reg_write_q, ex_reg_dst_q, ex_alu_src_q, ex_mem_read_q;
    logic              ex_mem_write_q, ex_mem_to_reg_q;
    logic [1:0]        ex_alu_op_q;
    logic [REG_AW-1:0] ex_dest_q;
    logic              ex_reg_write_d, ex_reg_dst_d, ex_alu_src_d, ex_mem_read_d;
    logic              ex_mem_write_d, ex_mem_to_reg_d;
    logic [1:0]        ex_alu_op_d;
    logic [REG_AW-1:0] ex_dest_d;
    // EX/MEM
    logic              mem_reg_write_q, mem_mem_read_q, mem_mem_write_q, mem_mem_to_reg_q;
    logic [REG_AW-1:0] mem_dest_q;
    // MEM/WB
    logic              wb_reg_write_q, wb_mem_to_reg_q;

    logic load_use, br_hazard, stall, taken;

    always_comb begin
        id_reg_write  = 1'b0;
        id_reg_dst    = 1'b0;
        id_alu_src    = 1'b0;
        id_mem_read   = 1'b0;
        id_mem_write  = 1'b0;
        id_mem_to_reg = 1'b0;
        id_alu_op     = 2'b00;
        uses_rs       = 1'b0;
        uses_rt       = 1'b0;
        case (bus.opCode)
            OpRtype: begin
                id_reg_write = 1'b1; id_reg_dst = 1'b1; id_alu_op = 2'b10;
                uses_rs = 1'b1; uses_rt = 1'b1;
            end
            OpAddi: begin
                id_reg_write = 1'b1; id_alu_src = 1'b1; uses_rs = 1'b1;
            end
            OpAndi: begin
                id_reg_write = 1'b1; id_alu_src = 1'b1; id_alu_op = 2'b11; uses_rs = 1'b1;
            end
            OpLw: begin
                id_reg_write = 1'b1; id_alu_src = 1'b1; id_mem_read = 1'b1;
                id_mem_to_reg = 1'b1; uses_rs = 1'b1;
            end
            OpSw: begin
                id_mem_write = 1'b1; id_alu_src = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
            end
            OpBeq, OpBne: begin
                id_alu_op = 2'b01; uses_rs = 1'b1; uses_rt = 1'b1;
            end
            default: ;
        endcase
        id_dest   = id_reg_dst ? bus.id_rd : bus.id_rt;
        is_branch = (bus.opCode == OpBeq) || (bus.opCode == OpBne);
        is_jump   = (bus.opCode == OpJ);
        taken     = ((bus.opCode == OpBeq) && bus.equal) || ((bus.opCode == OpBne) && !bus.equal);

        // Only lw sets memRead, so a memRead flag in EX identifies a load there.
        load_use  = ex_mem_read_q && (ex_dest_q != '0) &&
                    ((uses_rs && (ex_dest_q == bus.id_rs)) || (uses_rt && (ex_dest_q == bus.id_rt)));
        br_hazard = is_branch &&
                    ((ex_reg_write_q && (ex_dest_q != '0) &&
                      ((ex_dest_q == bus.id_rs) || (ex_dest_q == bus.id_rt))) ||
                     (mem_mem_read_q && (mem_dest_q != '0) &&
                      ((mem_dest_q == bus.id_rs) || (mem_dest_q == bus.id_rt))));
        stall     = load_use || br_hazard;

        bus.pc_write   = rst && !stall;
        bus.ifid_write = rst && !stall;
        bus.pcSrc      = 2'b00;
        bus.clear_IFID = 1'b0;
        if (rst && !stall) begin
            if (is_jump) begin
                bus.pcSrc      = 2'b10;
                bus.clear_IFID = 1'b1;
            end else if (taken) begin
                bus.pcSrc      = 2'b01;
                bus.clear_IFID = 1'b1;
            end
        end

        ex_reg_write_d  = id_reg_write  && !stall;
        ex_reg_dst_d    = id_reg_dst    && !stall;
        ex_alu_src_d    = id_alu_src    && !stall;
        ex_mem_read_d   = id_mem_read   && !stall;
        ex_mem_write_d  = id_mem_write  && !stall;
        ex_mem_to_reg_d = id_mem_to_reg && !stall;
        ex_alu_op_d     = stall ? 2'b00 : id_alu_op;
        ex_dest_d       = stall ? '0 : id_dest;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_reg_write_q   <= 1'b0;
            ex_reg_dst_q     <= 1'b0;
            ex_alu_src_q     <= 1'b0;
            ex_mem_read_q    <= 1'b0;
            ex_mem_write_q   <= 1'b0;
            ex_mem_to_reg_q  <= 1'b0;
            ex_alu_op_q      <= 2'b00;
            ex_dest_q        <= '0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_read_q   <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            mem_dest_q       <= '0;
            wb_reg_write_q   <= 1'b0;
            wb_mem_to_reg_q  <= 1'b0;
        end else begin
            ex_reg_write_q   <= ex_reg_write_d;
            ex_reg_dst_q     <= ex_reg_dst_d;
            ex_alu_src_q     <= ex_alu_src_d;
            ex_mem_read_q    <= ex_mem_read_d;
            ex_mem_write_q   <= ex_mem_write_d;
            ex_mem_to_reg_q  <= ex_mem_to_reg_d;
            ex_alu_op_q      <= ex_alu_op_d;
            ex_dest_q        <= ex_dest_d;
            mem_reg_write_q  <= ex_reg_write_q;
            mem_mem_read_q   <= ex_mem_read_q;
            mem_mem_write_q  <= ex_mem_write_q;
            mem_mem_to_reg_q <= ex_mem_to_reg_q;
            mem_dest_q       <= ex_dest_q;
            wb_reg_write_q   <= mem_reg_write_q;
            wb_mem_to_reg_q  <= mem_mem_to_reg_q;
        end
    end

    assign bus.ex_ALUSrc       = ex_alu_src_q;
    assign bus.ex_ALUOperation = ex_alu_op_q;
    assign bus.ex_regDst       = ex_reg_dst_q;
    assign bus.mem_memRead     = mem_mem_read_q;
    assign bus.mem_memWrite    = mem_mem_write_q;
    assign bus.wb_regWrite     = wb_reg_write_q;
    assign bus.wb_memtoReg     = wb_mem_to_reg_q;

`ifdef PIPE_CTRL_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (bus.clear_IFID && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;
`else
    assign bus.stall_count = {CNT_W{1'b0}};
    assign bus.flush_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_hazard_controller.sv
// Table-driven bench for pipe_hazard_controller; a second instance with CNT_W=2 covers
// counter saturation when PIPE_CTRL_STATS_EN is defined.
module tb_pipe_hazard_controller;
    localparam logic [5:0] OpR   = 6'b000000;
    localparam logic [5:0] OpAdd = 6'b001000;
    localparam logic [5:0] OpAnd = 6'b001100;
    localparam logic [5:0] OpLw  = 6'b100011;
    localparam logic [5:0] OpSw  = 6'b101011;
    localparam logic [5:0] OpBeq = 6'b000100;
    localparam logic [5:0] OpBne = 6'b000101;
    localparam logic [5:0] OpJ   = 6'b000010;
    localparam logic [5:0] OpNop = 6'b111111;
    localparam int NumVec = 29;

`ifdef PIPE_CTRL_STATS_EN
    localparam int ExpCnt    = 4;
    localparam int ExpSatCnt = 3;
`else
    localparam int ExpCnt    = 0;
    localparam int ExpSatCnt = 0;
`endif

    // ctl = {pc_write, ifid_write, pcSrc, clear_IFID}; ex = {ALUSrc, ALUOperation, regDst};
    // mem = {memRead, memWrite}; wb = {regWrite, memtoReg}
    typedef struct {
        logic [5:0] op;
        logic       eq;
        logic [4:0] rs, rt, rd;
        logic [4:0] ctl;
        logic [3:0] ex;
        logic [1:0] mem;
        logic [1:0] wb;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[NumVec];

    pipe_hazard_controller_if #(.REG_AW(5), .CNT_W(16)) bus ();
    pipe_hazard_controller_if #(.REG_AW(5), .CNT_W(2))  bus_sat ();

    pipe_hazard_controller #(.REG_AW(5), .CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    pipe_hazard_controller #(.REG_AW(5), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .bus(bus_sat)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus_sat.opCode = bus.opCode;
        bus_sat.equal  = bus.equal;
        bus_sat.id_rs  = bus.id_rs;
        bus_sat.id_rt  = bus.id_rt;
        bus_sat.id_rd  = bus.id_rd;
    end

    function automatic logic [4:0] act_ctl();
        return {bus.pc_write, bus.ifid_write, bus.pcSrc, bus.clear_IFID};
    endfunction

    function automatic logic [3:0] act_ex();
        return {bus.ex_ALUSrc, bus.ex_ALUOperation, bus.ex_regDst};
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic eq, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd);
        bus.opCode = op;
        bus.equal  = eq;
        bus.id_rs  = rs;
        bus.id_rt  = rt;
        bus.id_rd  = rd;
    endtask

    task automatic check_regs_zero(input string name, input int idx);
        check({name, "_ex"}, idx, 16'(act_ex()), 16'h0);
        check({name, "_mem"}, idx, 16'({bus.mem_memRead, bus.mem_memWrite}), 16'h0);
        check({name, "_wb"}, idx, 16'({bus.wb_regWrite, bus.wb_memtoReg}), 16'h0);
    endtask

    initial begin
        vecs[0]  = '{OpAdd, 1'b0, 5'd1, 5'd2, 5'd0, 5'b11000, 4'b0000, 2'b00, 2'b00};
        vecs[1]  = '{OpNop, 1'b0, 5'd0, 5'd0, 5'd0, 5'b11000, 4'b1000, 2'b00, 2'b00};
        vecs[2]  = '{OpNop, 1'b0, 5'd0, 5'd0, 5'd0, 5'b11000, 4'b0000, 2'b00, 2'b00};
        vecs[3]  = '{OpNop, 1'b0, 5'd0, 5'd0, 5'd0, 5'b11000, 4'b0000, 2'b00, 2'b10};
        vecs[4]  = '{OpLw,  1'b0, 5'd1, 5'd5, 5'd0, 5'b11000, 4'b0000, 2'b00, 2'b00};
        vecs[5]  = '{OpR,   1'b0, 5'd5, 5'd6, 5'd7, 5'b00000, 4'b1000, 2'b00, 2'b00};
        vecs[6]  = '{OpR,   1'b0, 5'd5, 5'd6, 5'd7, 5'b11000, 4'b0000, 2'b10, 2'b00};
        vecs[7]  = '{OpNop, 1'b0, 5'd0, 5'd0, 5'd0, 5'b11000, 4'b0101, 2'b00, 2'b11};
        vecs[8]  = '{OpLw,  1'b0, 5'd0, 5'd5, 5'd0, 5'b11000, 4'b0000, 2'b00, 2'b00};
        vecs[9]  = '{OpR,   1'b0, 5'd0, 5'd0, 5'd3, 5'b11000, 4'b1000, 2'b00, 2'b10};
        vecs[10] = '{OpLw,  1'b0, 5'd0, 5'd7, 5'd0, 5'b11000, 4'b0101, 2'b10, 2'b00};
        vecs[11] = '{OpBeq, 1'b1, 5'd1, 5'd7, 5'd0, 5'b00000, 4'b1000, 2'b00, 2'b11};
        vecs[12] = '{OpBeq, 1'b1, 5'd1, 5'd7, 5'd0, 5'b00000, 4'b0000, 2'b10, 2'b10};
        vecs[13] = '{OpBeq, 1'b1, 5'd1, 5'd7, 5'd0, 5'b11011, 4'b0000, 2'b00, 2'b11};
        vecs[14] = '{OpBne, 1'b1, 5'd2, 5'd3, 5'd0, 5'b11000, 4'b0010, 2'b00, 2'b00};
        vecs[15] = '{OpBne, 1'b0, 5'd2, 5'd3, 5'd0, 5'b11011, 4'b0010, 2'b00, 2'b00};
        vecs[16] = '{OpJ,   1'b0, 5'd0, 5'd0, 5'd0, 5'b11101, 4'b0010, 2'b00, 2'b00};
        vecs[17] = '{OpNop, 1'b0, 5'd0, 5'd0, 5'd0, 5'b11000, 4'b0000, 2'b00, 2'b00};
        vecs[18] = '{OpSw,  1'b0, 5'd4, 5'd5, 5'd0, 5'b11000, 4'b0000, 2'b00, 2'b00};
        vecs[19] = '{OpAnd, 1'b0, 5'd1, 5'd2, 5'd0, 5'b11000, 4'b1000, 2'b00, 2'b00};
        vecs[20] = '{OpAdd, 1'b0, 5'd2, 5'd3, 5'd0, 5'b11000, 4'b1110, 2'b01, 2'b00};
        vecs[21] = '{OpNop, 1'b0, 5'd0, 5'd0, 5'd0, 5'b11000, 4'b1000, 2'b00, 2'b00};
        vecs[22] = '{OpBeq, 1'b0, 5'd3, 5'd0, 5'd0, 5'b11000, 4'b0000, 2'b00, 2'b10};
        vecs[23] = '{OpAdd, 1'b0, 5'd0, 5'd9, 5'd0, 5'b11000, 4'b0010, 2'b00, 2'b10};
        vecs[24] = '{OpBeq, 1'b1, 5'd9, 5'd1, 5'd0, 5'b00000, 4'b1000, 2'b00, 2'b00};
        vecs[25] = '{OpBeq, 1'b1, 5'd9, 5'd1, 5'd0, 5'b11011, 4'b0000, 2'b00, 2'b00};
        vecs[26] = '{OpNop, 1'b0, 5'd0, 5'd0, 5'd0, 5'b11000, 4'b0010, 2'b00, 2'b10};
        vecs[27] = '{OpLw,  1'b0, 5'd0, 5'd0, 5'd0, 5'b11000, 4'b0000, 2'b00, 2'b00};
        vecs[28] = '{OpBeq, 1'b0, 5'd0, 5'd0, 5'd0, 5'b11000, 4'b1000, 2'b00, 2'b00};

        // Reset with a jump in ID: the forced outputs must override the redirect.
        drive(OpJ, 1'b0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", 0, 16'(act_ctl()), 16'h0);
        check_regs_zero("rst", 0);
        check("rst_stall_cnt", 0, bus.stall_count, 16'h0);
        check("rst_flush_cnt", 0, bus.flush_count, 16'h0);

        for (int i = 0; i < NumVec; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            drive(vecs[i].op, vecs[i].eq, vecs[i].rs, vecs[i].rt, vecs[i].rd);
            @(negedge clk);
            check("ctl", i, 16'(act_ctl()), 16'(vecs[i].ctl));
            check("ex", i, 16'(act_ex()), 16'(vecs[i].ex));
            check("mem", i, 16'({bus.mem_memRead, bus.mem_memWrite}), 16'(vecs[i].mem));
            check("wb", i, 16'({bus.wb_regWrite, bus.wb_memtoReg}), 16'(vecs[i].wb));
        end

        @(posedge clk);
        #1;
        drive(OpNop, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        check("stall_cnt", 0, bus.stall_count, 16'(ExpCnt));
        check("flush_cnt", 0, bus.flush_count, 16'(ExpCnt));
        check("sat_stall_cnt", 0, 16'(bus_sat.stall_count), 16'(ExpSatCnt));
        check("sat_flush_cnt", 0, 16'(bus_sat.flush_count), 16'(ExpSatCnt));

        // Reset asserted in the middle of a load-use stall.
        @(posedge clk);
        #1;
        drive(OpLw, 1'b0, 5'd0, 5'd5, 5'd0);
        @(negedge clk);
        check("mid_lw_ctl", 0, 16'(act_ctl()), 16'b11000);
        @(posedge clk);
        #1;
        drive(OpR, 1'b0, 5'd5, 5'd6, 5'd7);
        @(negedge clk);
        check("mid_stall_ctl", 0, 16'(act_ctl()), 16'b00000);
        check("mid_stall_ex", 0, 16'(act_ex()), 16'b1000);
        rst = 1'b0;
        #1;
        check("mid_rst_ctl", 0, 16'(act_ctl()), 16'b00000);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_ctl", 0, 16'(act_ctl()), 16'b00000);
        check_regs_zero("post_rst", 0);
        check("post_rst_stall_cnt", 0, bus.stall_count, 16'h0);
        check("post_rst_flush_cnt", 0, bus.flush_count, 16'h0);
        check("post_rst_sat_cnt", 0, 16'(bus_sat.stall_count), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(OpNop, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        check("resume_ctl", 0, 16'(act_ctl()), 16'b11000);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_regs_zero("resume", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
